y86_instr_encoder: RTL and testbench

//  Writer side of the Y86-64 instruction memory. Accepts one decoded instruction per handshake
//  (icode, ifun, rA, rB, valC), serialises it into the byte layout the fetch stage parses
//  (1/2/9/10 bytes, valC little-endian), and writes one byte per cycle at an auto-incrementing pointer.

---
 rtl/y86_pkg.sv | 36 +++
 rtl/y86_instr_len.sv | 18 +
 rtl/y86_instr_encoder.sv | 128 ++++++++++++
 tb/tb_y86_instr_encoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Y86-64 ISA constants shared by the instruction-memory writer and the fetch/decode stages.
// The length table lives here so every consumer derives instruction size identically.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } enc_state_t;

  // Encoded size in bytes; 0 marks an icode outside the ISA.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET:                  instr_len = 4'd1;
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:  instr_len = 4'd2;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:          instr_len = 4'd10;
      ICODE_JXX, ICODE_CALL:                             instr_len = 4'd9;
      default:                                           instr_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode classifier: byte length plus which optional fields follow byte 0.
// Fetch uses the same block, so encoder and decoder cannot disagree on layout.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       has_regs,
  output logic       has_valc
);

  always_comb begin
    len      = instr_len(icode);
    has_regs = (len == 4'd2) || (len == 4'd10);
    has_valc = (len == 4'd9) || (len == 4'd10);
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction per handshake into instruction memory,
// one byte per cycle at an auto-incrementing write pointer.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int MEM_DEPTH = 128,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ptr_load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              err_invalid,
  output logic              err_overflow,
  output logic [15:0]       instr_count
);

  localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(MEM_DEPTH);

  enc_state_t        state;
  logic [3:0]        len;
  logic              has_regs;
  logic              has_valc;
  logic [79:0]       frame_in;
  logic [79:0]       frame_p0;
  logic [3:0]        cnt_p0;
  logic [ADDR_W+1:0] end_ptr;
  logic              overflow;
  logic              accept;

  y86_instr_len u_len (
    .icode    (icode),
    .len      (len),
    .has_regs (has_regs),
    .has_valc (has_valc)
  );

  assign in_ready = (state == ST_IDLE) && !ptr_load;
  assign end_ptr  = {1'b0, wr_ptr} + (ADDR_W+2)'(len);
  assign overflow = end_ptr > DEPTH;
  assign accept   = in_valid && in_ready && (len != 4'd0) && !overflow;

  // Byte 0 sits in the low octet; valC shifts up one byte when the register byte is present.
  always_comb begin
    frame_in      = '0;
    frame_in[7:0] = {icode, ifun};
    if (has_regs) begin
      frame_in[15:8] = {rA, rB};
      if (has_valc) frame_in[79:16] = valC;
    end else if (has_valc) begin
      frame_in[71:8] = valC;
    end
  end

  // Stage p0: capture shift register, low byte is always the next one to emit
  always_ff @(posedge clk) begin
    if (accept)
      frame_p0 <= {8'h00, frame_in[79:8]};
    else if (state == ST_EMIT)
      frame_p0 <= {8'h00, frame_p0[79:8]};
  end

  // Byte 0 is written on the handshake edge; EMIT writes the remaining len-1 bytes
  // and spends one final cycle with cnt_p0 == 0 before returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'h00;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
      instr_count  <= 16'd0;
      cnt_p0       <= 4'd0;
    end else begin
      mem_we       <= 1'b0;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ptr_load) begin
            wr_ptr <= {1'b0, load_addr};
          end else if (in_valid) begin
            if (len == 4'd0) begin
              err_invalid <= 1'b1;
            end else if (overflow) begin
              err_overflow <= 1'b1;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= wr_ptr[ADDR_W-1:0];
              mem_wdata <= frame_in[7:0];
              wr_ptr    <= wr_ptr + 1'b1;
              cnt_p0    <= len - 4'd1;
              state     <= ST_EMIT;
              if (len == 4'd1) instr_count <= instr_count + 16'd1;
            end
          end
        end
        ST_EMIT: begin
          if (cnt_p0 != 4'd0) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr[ADDR_W-1:0];
            mem_wdata <= frame_p0[7:0];
            wr_ptr    <= wr_ptr + 1'b1;
            cnt_p0    <= cnt_p0 - 4'd1;
            if (cnt_p0 == 4'd1) instr_count <= instr_count + 16'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Directed bench for y86_instr_encoder: a byte-array memory model collects writes and
// hand-computed byte images, pointers and pulses are compared against it.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ptr_load;
  logic [6:0]  load_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  wr_ptr;
  logic        err_invalid, err_overflow;
  logic [15:0] instr_count;

  logic [7:0]  mem [0:127];
  int          we_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  y86_instr_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ptr_load     (ptr_load),
    .load_addr    (load_addr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .icode        (icode),
    .ifun         (ifun),
    .rA           (rA),
    .rB           (rB),
    .valC         (valC),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .wr_ptr       (wr_ptr),
    .err_invalid  (err_invalid),
    .err_overflow (err_overflow),
    .instr_count  (instr_count)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt        <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    int c;
    wait_ready("send", c);
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_ptr(input logic [6:0] a);
    ptr_load  = 1'b1;
    load_addr = a;
    tick();
    ptr_load  = 1'b0;
  endtask

  localparam logic [63:0] IRM_C = 64'h0123456789ABCDEF;

  initial begin
    logic [7:0] irm_b [10];
    int cyc;
    int w0;
    irm_b = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

    rst_n = 1'b0; ptr_load = 1'b0; load_addr = '0; in_valid = 1'b0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
    tick(); tick(); tick();
    chk("rst_we", mem_we, 0);
    chk("rst_ptr", wr_ptr, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt", instr_count, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // irmovq $0x0123456789ABCDEF, %rdx at address 0
    w0 = we_cnt;
    send(4'h3, 4'h0, 4'hF, 4'h2, IRM_C);
    chk("irm_we_n1", mem_we, 1);
    chk("irm_addr_n1", mem_addr, 0);
    chk("irm_data_n1", mem_wdata, 8'h30);
    chk("irm_busy", in_ready, 0);
    wait_ready("irm", cyc);
    chk("irm_lat", cyc, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("irm_b%0d", i), mem[i], irm_b[i]);
    chk("irm_ptr", wr_ptr, 10);
    chk("irm_cnt", instr_count, 1);
    chk("irm_nwe", we_cnt - w0, 10);

    // addq %rcx,%rbx then halt, back to back
    send(4'h6, 4'h0, 4'h1, 4'h3, 64'h0);
    chk("add_busy", in_ready, 0);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    wait_ready("halt", cyc);
    chk("add_b0", mem[10], 8'h60);
    chk("add_b1", mem[11], 8'h13);
    chk("halt_b0", mem[12], 8'h00);
    chk("halt_ptr", wr_ptr, 13);
    chk("halt_cnt", instr_count, 3);

    // jmp 0x20 with non-NONE register fields that must not appear
    send(4'h7, 4'h0, 4'h5, 4'h6, 64'h20);
    wait_ready("jmp", cyc);
    chk("jmp_lat", cyc, 9);
    chk("jmp_b0", mem[13], 8'h70);
    chk("jmp_b1", mem[14], 8'h20);
    for (int i = 15; i < 22; i++) chk($sformatf("jmp_z%0d", i), mem[i], 8'h00);
    chk("jmp_ptr", wr_ptr, 22);
    chk("jmp_cnt", instr_count, 4);

    // ptr_load wins over a simultaneous valid instruction
    w0 = we_cnt;
    ptr_load = 1'b1; load_addr = 7'd120;
    icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h2; valC = IRM_C;
    in_valid = 1'b1;
    #1;
    chk("pl_block", in_ready, 0);
    tick();
    ptr_load = 1'b0; in_valid = 1'b0;
    chk("pl_ptr", wr_ptr, 120);
    send(4'h3, 4'h0, 4'hF, 4'h2, IRM_C);
    chk("ovf_pulse", err_overflow, 1);
    chk("ovf_we", mem_we, 0);
    chk("ovf_idle", in_ready, 1);
    tick();
    chk("ovf_clear", err_overflow, 0);
    chk("ovf_ptr", wr_ptr, 120);
    chk("ovf_nwe", we_cnt - w0, 0);

    // last byte of memory is still usable, then memory is full
    load_ptr(7'd127);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
    wait_ready("nop", cyc);
    chk("nop_lat", cyc, 1);
    chk("nop_b0", mem[127], 8'h10);
    chk("nop_ptr", wr_ptr, 128);
    chk("nop_cnt", instr_count, 5);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
    chk("full_ovf", err_overflow, 1);
    chk("full_we", mem_we, 0);
    wait_ready("full", cyc);
    chk("full_ptr", wr_ptr, 128);

    // invalid icode
    w0 = we_cnt;
    send(4'hC, 4'h0, 4'hF, 4'hF, 64'h0);
    chk("inv_pulse", err_invalid, 1);
    chk("inv_noovf", err_overflow, 0);
    tick();
    chk("inv_clear", err_invalid, 0);
    chk("inv_nwe", we_cnt - w0, 0);
    chk("inv_cnt", instr_count, 5);

    // reset while byte 4 of an irmovq is on the bus
    load_ptr(7'd30);
    w0 = we_cnt;
    send(4'h3, 4'h0, 4'hF, 4'h2, IRM_C);
    tick(); tick(); tick(); tick();
    chk("mid_addr", mem_addr, 34);
    chk("mid_data", mem_wdata, 8'hAB);
    rst_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_ptr", wr_ptr, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_cnt", instr_count, 0);
    tick(); tick();
    chk("abort_nwe", we_cnt - w0, 4);
    chk("abort_b3", mem[33], 8'hCD);
    rst_n = 1'b1;
    tick();
    send(4'h9, 4'h0, 4'hF, 4'hF, 64'h0);
    wait_ready("ret", cyc);
    chk("ret_b0", mem[0], 8'h90);
    chk("ret_ptr", wr_ptr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
